mult16_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one signed 16x16 fixed-point multiplier (`signed_mult_16`, combinational, Q8.8, ports A, B, C) among `N_REQ` requesters. It accepts one operand pair per transaction through a valid/ready handshake and drives the multiplier from registered operands. It returns the product with the requester index on a single valid/ready result port. It sits between the filter/control engines and the single multiplier instance, so the multiplier is not replicated per engine.

---
 rtl/mult16_rr_arbiter.sv | 134 +++++++++++++
 tb/tb_mult16_rr_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mult16_rr_arbiter.sv
// Round-robin arbiter that time-shares one external signed Q8.8 multiplier
// among N_REQ requesters; operands registered, result held until consumed.
module mult16_rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDW   = $clog2(N_REQ)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [N_REQ-1:0]      REQ_VALID,
  input  logic [16*N_REQ-1:0]   REQ_A,
  input  logic [16*N_REQ-1:0]   REQ_B,
  output logic [N_REQ-1:0]      REQ_READY,
  output logic [15:0]           MULT_A,
  output logic [15:0]           MULT_B,
  input  logic [15:0]           MULT_C,
  output logic                  RES_VALID,
  output logic [15:0]           RES_DATA,
  output logic [IDW-1:0]        RES_ID,
  input  logic                  RES_READY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [15:0]    mult_a_q, mult_a_d;
  logic [15:0]    mult_b_q, mult_b_d;
  logic [15:0]    res_data_q, res_data_d;
  logic [IDW-1:0] res_id_q, res_id_d;
  logic           res_valid_q, res_valid_d;

  logic           accept_window;
  logic           found;
  logic           grant;
  logic [IDW-1:0] win_idx;
  logic [15:0]    win_a;
  logic [15:0]    win_b;
  int unsigned    idx;

  // Search upward from ptr_q with wrap; the first valid index wins.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    win_a   = '0;
    win_b   = '0;
    idx     = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && REQ_VALID[idx]) begin
        found   = 1'b1;
        win_idx = IDW'(idx);
        win_a   = REQ_A[16*idx +: 16];
        win_b   = REQ_B[16*idx +: 16];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    mult_a_d    = mult_a_q;
    mult_b_d    = mult_b_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    res_valid_d = res_valid_q;
    REQ_READY   = '0;

    accept_window = (state_q == IDLE) || ((state_q == DONE) && RES_READY);
    grant         = accept_window && found;

    case (state_q)
      CALC: begin
        res_data_d  = MULT_C;
        res_id_d    = id_q;
        res_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (RES_READY) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      IDLE: ;
      default: state_d = IDLE;
    endcase

    // A grant in DONE overrides the return to IDLE so accepts run back-to-back.
    if (grant) begin
      mult_a_d = win_a;
      mult_b_d = win_b;
      id_d     = win_idx;
      ptr_d    = (win_idx == IDW'(N_REQ - 1)) ? '0 : win_idx + IDW'(1);
      state_d  = CALC;
      if (RST_N) REQ_READY[win_idx] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      mult_a_q    <= '0;
      mult_b_q    <= '0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      mult_a_q    <= mult_a_d;
      mult_b_q    <= mult_b_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign MULT_A    = mult_a_q;
  assign MULT_B    = mult_b_q;
  assign RES_DATA  = res_data_q;
  assign RES_ID    = res_id_q;
  assign RES_VALID = res_valid_q;

endmodule

// File: tb/tb_mult16_rr_arbiter.sv
// Directed bench for mult16_rr_arbiter with a behavioural Q8.8 multiplier
// standing in for signed_mult_16.
module tb_mult16_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [3:0]  req_ready;
  logic [15:0] mult_a;
  logic [15:0] mult_b;
  logic [15:0] mult_c;
  logic        res_valid;
  logic [15:0] res_data;
  logic [1:0]  res_id;
  logic        res_ready;
  logic signed [31:0] prod;

  int checks = 0;
  int errors = 0;

  mult16_rr_arbiter #(.N_REQ(4), .IDW(2)) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .REQ_VALID (req_valid),
    .REQ_A     (req_a),
    .REQ_B     (req_b),
    .REQ_READY (req_ready),
    .MULT_A    (mult_a),
    .MULT_B    (mult_b),
    .MULT_C    (mult_c),
    .RES_VALID (res_valid),
    .RES_DATA  (res_data),
    .RES_ID    (res_id),
    .RES_READY (res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Q8.8 x Q8.8 -> Q8.8, truncating the low fraction bits.
  always_comb begin
    prod   = $signed(mult_a) * $signed(mult_b);
    mult_c = prod[23:8];
  end

  typedef struct {
    logic        rst_n;
    logic [3:0]  v;
    logic [63:0] a;
    logic [63:0] b;
    logic        rr;
    logic [3:0]  e_rdy;
    logic [15:0] e_ma;
    logic [15:0] e_mb;
    logic        e_rv;
    logic [15:0] e_rd;
    logic [1:0]  e_id;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic [3:0] v, input logic [63:0] a,
                       input logic [63:0] b, input logic rr);
    @(negedge clk);
    rst_n     = r;
    req_valid = v;
    req_a     = a;
    req_b     = b;
    res_ready = rr;
    #1;
  endtask

  task automatic chk_res(input string tag, input logic rv, input logic [15:0] rd,
                         input logic [1:0] id);
    chk($sformatf("%s res_valid", tag), {15'd0, res_valid}, {15'd0, rv});
    chk($sformatf("%s res_data", tag), res_data, rd);
    chk($sformatf("%s res_id", tag), {14'd0, res_id}, {14'd0, id});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [63:0] a_rr, b_rr, a6, b6;
  logic [15:0] e16;
  int j, p;

  initial begin
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b0;

    //         rst   v       a                        b                        rr    rdy    ma        mb        rv    rd        id
    tbl[0]  = '{1'b0, 4'hF, 64'h0,                   64'h0,                   1'b1, 4'h0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 2'd0};
    tbl[1]  = '{1'b0, 4'hF, 64'h0,                   64'h0,                   1'b1, 4'h0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 2'd0};
    tbl[2]  = '{1'b0, 4'hF, 64'h0,                   64'h0,                   1'b1, 4'h0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 2'd0};
    tbl[3]  = '{1'b1, 4'h1, 64'h0000_0000_0000_0300, 64'h0000_0000_0000_0400, 1'b1, 4'h1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 2'd0};
    tbl[4]  = '{1'b1, 4'h0, 64'h0,                   64'h0,                   1'b1, 4'h0, 16'h0300, 16'h0400, 1'b0, 16'h0000, 2'd0};
    tbl[5]  = '{1'b1, 4'h0, 64'h0,                   64'h0,                   1'b1, 4'h0, 16'h0300, 16'h0400, 1'b1, 16'h0C00, 2'd0};
    tbl[6]  = '{1'b1, 4'h4, 64'h0000_FC00_0000_0000, 64'h0000_FE00_0000_0000, 1'b1, 4'h4, 16'h0300, 16'h0400, 1'b0, 16'h0C00, 2'd0};
    tbl[7]  = '{1'b1, 4'h0, 64'h0,                   64'h0,                   1'b1, 4'h0, 16'hFC00, 16'hFE00, 1'b0, 16'h0C00, 2'd0};
    tbl[8]  = '{1'b1, 4'h4, 64'h0000_0300_0000_0000, 64'h0000_FE00_0000_0000, 1'b1, 4'h4, 16'hFC00, 16'hFE00, 1'b1, 16'h0800, 2'd2};
    tbl[9]  = '{1'b1, 4'h0, 64'h0,                   64'h0,                   1'b1, 4'h0, 16'h0300, 16'hFE00, 1'b0, 16'h0800, 2'd2};
    tbl[10] = '{1'b1, 4'h0, 64'h0,                   64'h0,                   1'b0, 4'h0, 16'h0300, 16'hFE00, 1'b1, 16'hFA00, 2'd2};
    tbl[11] = '{1'b1, 4'h0, 64'h0,                   64'h0,                   1'b1, 4'h0, 16'h0300, 16'hFE00, 1'b1, 16'hFA00, 2'd2};
    tbl[12] = '{1'b1, 4'h0, 64'h0,                   64'h0,                   1'b1, 4'h0, 16'h0300, 16'hFE00, 1'b0, 16'hFA00, 2'd2};

    // Bring registers out of X before the first checked reset cycle.
    apply(1'b0, 4'hF, '0, '0, 1'b1);

    for (int i = 0; i < 13; i++) begin
      apply(tbl[i].rst_n, tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].rr);
      chk($sformatf("vec%0d req_ready", i), {12'd0, req_ready}, {12'd0, tbl[i].e_rdy});
      chk($sformatf("vec%0d mult_a", i), mult_a, tbl[i].e_ma);
      chk($sformatf("vec%0d mult_b", i), mult_b, tbl[i].e_mb);
      chk_res($sformatf("vec%0d", i), tbl[i].e_rv, tbl[i].e_rd, tbl[i].e_id);
    end

    // Round-robin from reset: requester i offers (i+1.0) x 2.0.
    a_rr = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
    b_rr = {4{16'h0200}};
    apply(1'b0, 4'hF, a_rr, b_rr, 1'b1);
    chk("rr reset req_ready", {12'd0, req_ready}, 16'h0000);
    for (int k = 0; k <= 12; k++) begin
      apply(1'b1, 4'hF, a_rr, b_rr, 1'b1);
      j = k / 2;
      if (k % 2 == 0) begin
        e16 = 16'(1 << (j % 4));
        chk($sformatf("rr%0d req_ready", k), {12'd0, req_ready}, e16);
        if (k >= 2) begin
          p = (j - 1) % 4;
          chk_res($sformatf("rr%0d", k), 1'b1, 16'((p + 1) * 16'h0200), 2'(p));
        end
      end else begin
        chk($sformatf("rr%0d req_ready", k), {12'd0, req_ready}, 16'h0000);
        chk($sformatf("rr%0d res_valid", k), {15'd0, res_valid}, 16'h0000);
        chk($sformatf("rr%0d mult_a", k), mult_a, 16'(((j % 4) + 1) << 8));
      end
    end

    // Backpressure: requester 2 in CALC, requesters 1 and 3 waiting.
    apply(1'b1, 4'b1010, a_rr, b_rr, 1'b1);
    chk("bp calc req_ready", {12'd0, req_ready}, 16'h0000);
    chk("bp calc res_valid", {15'd0, res_valid}, 16'h0000);
    for (int k = 0; k < 5; k++) begin
      apply(1'b1, 4'b1010, a_rr, b_rr, 1'b0);
      chk($sformatf("bp%0d req_ready", k), {12'd0, req_ready}, 16'h0000);
      chk_res($sformatf("bp%0d", k), 1'b1, 16'h0600, 2'd2);
    end
    apply(1'b1, 4'b1010, a_rr, b_rr, 1'b1);
    chk("bp release req_ready", {12'd0, req_ready}, 16'h0008);
    chk_res("bp release", 1'b1, 16'h0600, 2'd2);
    apply(1'b1, 4'b0010, a_rr, b_rr, 1'b1);
    chk("bp calc3 req_ready", {12'd0, req_ready}, 16'h0000);
    chk("bp calc3 mult_a", mult_a, 16'h0400);
    apply(1'b1, 4'b0010, a_rr, b_rr, 1'b1);
    chk("bp next req_ready", {12'd0, req_ready}, 16'h0002);
    chk_res("bp next", 1'b1, 16'h0800, 2'd3);

    // Reset while CALC: the in-flight result must vanish and ptr return to 0.
    a6 = {16'h0000, 16'h0100, 16'h0000, 16'h0000};
    b6 = {16'h0000, 16'h0100, 16'h0000, 16'h0000};
    apply(1'b0, 4'h0, a6, b6, 1'b1);
    chk("mr rst0 req_ready", {12'd0, req_ready}, 16'h0000);
    apply(1'b1, 4'b0100, a6, b6, 1'b1);
    chk("mr grant req_ready", {12'd0, req_ready}, 16'h0004);
    apply(1'b0, 4'hF, a6, b6, 1'b1);
    chk("mr rst1 req_ready", {12'd0, req_ready}, 16'h0000);
    apply(1'b1, 4'h0, a6, b6, 1'b1);
    chk("mr after req_ready", {12'd0, req_ready}, 16'h0000);
    chk("mr after mult_a", mult_a, 16'h0000);
    chk("mr after mult_b", mult_b, 16'h0000);
    chk_res("mr after", 1'b0, 16'h0000, 2'd0);
    apply(1'b1, 4'h0, a6, b6, 1'b1);
    chk("mr idle res_valid", {15'd0, res_valid}, 16'h0000);
    a6 = {16'h0700, 16'h0000, 16'h0100, 16'h0000};
    b6 = {16'h0700, 16'h0000, 16'h0300, 16'h0000};
    apply(1'b1, 4'b1010, a6, b6, 1'b1);
    chk("mr ptr0 req_ready", {12'd0, req_ready}, 16'h0002);
    apply(1'b1, 4'b1000, a6, b6, 1'b0);
    chk("mr calc res_valid", {15'd0, res_valid}, 16'h0000);
    chk("mr calc mult_a", mult_a, 16'h0100);
    chk("mr calc mult_b", mult_b, 16'h0300);
    apply(1'b1, 4'b1000, a6, b6, 1'b0);
    chk_res("mr done", 1'b1, 16'h0300, 2'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
